// File: rtl/fpu_issue_scheduler_if.sv
// Handshake bundle between decode/issue, the FPU unit launch inputs, the divider
// writeback arbitration and the normalizer writeback port.
interface fpu_issue_scheduler_if;
    logic       issue_valid;
    logic [2:0] issue_op;
    logic [4:0] issue_dest;
    logic [4:0] issue_src_a;
    logic [4:0] issue_src_b;
    logic       issue_ready;
    logic       add_start;
    logic       mult_start;
    logic       i2f_start;
    logic       f2i_start;
    logic       fcmp_start;
    logic       div_start;
    logic       div_done;
    logic       div_wb_grant;
    logic       wb_valid;
    logic [4:0] wb_dest;
    logic       fpu_busy;

    // Environment side: decode stage, FPU units and normalizer.
    modport master (
        output issue_valid, issue_op, issue_dest, issue_src_a, issue_src_b,
        output div_done, wb_valid, wb_dest,
        input  issue_ready, add_start, mult_start, i2f_start, f2i_start,
        input  fcmp_start, div_start, div_wb_grant, fpu_busy
    );

    // Scheduler side.
    modport slave (
        input  issue_valid, issue_op, issue_dest, issue_src_a, issue_src_b,
        input  div_done, wb_valid, wb_dest,
        output issue_ready, add_start, mult_start, i2f_start, f2i_start,
        output fcmp_start, div_start, div_wb_grant, fpu_busy
    );
endinterface

// File: rtl/fpu_issue_scheduler.sv
// FPU issue controller: books the single normalizer input slot for fixed-latency
// ops, interlocks on pending destination registers and parks divider results.
module fpu_issue_scheduler #(
    parameter int ADD_LAT  = 3,
    parameter int MUL_LAT  = 3,
    parameter int I2F_LAT  = 2,
    parameter int F2I_LAT  = 2,
    parameter int FCMP_LAT = 1,
    parameter int LAT_MAX  = 4
) (
    input logic                  clock,
    input logic                  resetn,
    fpu_issue_scheduler_if.slave bus
);
    localparam int LAT_W = $clog2(LAT_MAX + 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_I2F  = 3'd2;
    localparam logic [2:0] OP_F2I  = 3'd3;
    localparam logic [2:0] OP_FCMP = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_WAIT_WB
    } div_state_t;

    div_state_t         div_state_q, div_state_d;
    logic [LAT_MAX-1:0] slot_q, slot_d;
    logic [LAT_MAX:0]   slot_ext;
    logic [LAT_MAX-1:0] book_mask;
    logic [31:0]        pending_q, pending_d;
    logic [31:0]        set_mask, clr_mask;
    logic [LAT_W-1:0]   lat;
    logic               op_legal, op_is_div, op_uses_b;
    logic               hazard, slot_free, ready, fire;

    // Decode the offered op into its result latency and operand usage.
    always_comb begin
        lat       = '0;
        op_legal  = 1'b1;
        op_is_div = 1'b0;
        op_uses_b = 1'b1;
        case (bus.issue_op)
            OP_ADD:  lat = LAT_W'(ADD_LAT);
            OP_MUL:  lat = LAT_W'(MUL_LAT);
            OP_I2F:  begin lat = LAT_W'(I2F_LAT); op_uses_b = 1'b0; end
            OP_F2I:  begin lat = LAT_W'(F2I_LAT); op_uses_b = 1'b0; end
            OP_FCMP: lat = LAT_W'(FCMP_LAT);
            OP_DIV:  op_is_div = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // The extra zero on top makes a latency of LAT_MAX always find its slot free.
    assign slot_ext  = {1'b0, slot_q};
    assign slot_free = ~slot_ext[lat];
    assign hazard    = pending_q[bus.issue_dest] | pending_q[bus.issue_src_a]
                     | (pending_q[bus.issue_src_b] & op_uses_b);
    assign ready     = op_legal & ~hazard
                     & (op_is_div ? (div_state_q == DIV_IDLE) : slot_free);
    assign fire      = bus.issue_valid & ready;

    assign bus.issue_ready = ready;
    assign bus.fpu_busy    = (|pending_q) | (div_state_q != DIV_IDLE);

    // A fixed op of latency L lands at index L-1 so it reaches index 0 L cycles later.
    always_comb begin
        book_mask = '0;
        if (fire && !op_is_div) begin
            book_mask = LAT_MAX'(1) << (lat - LAT_W'(1));
        end
        slot_d = slot_ext[LAT_MAX:1] | book_mask;
    end

    always_comb begin
        set_mask  = fire ? (32'd1 << bus.issue_dest) : 32'd0;
        clr_mask  = bus.wb_valid ? (32'd1 << bus.wb_dest) : 32'd0;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            slot_q      <= '0;
            pending_q   <= '0;
            div_state_q <= DIV_IDLE;
        end else begin
            slot_q      <= slot_d;
            pending_q   <= pending_d;
            div_state_q <= div_state_d;
        end
    end

    // The divider result waits until no fixed-latency result occupies the normalizer.
    always_comb begin
        div_state_d = div_state_q;
        case (div_state_q)
            DIV_IDLE:    if (fire && op_is_div) div_state_d = DIV_BUSY;
            DIV_BUSY:    if (bus.div_done)      div_state_d = DIV_WAIT_WB;
            DIV_WAIT_WB: if (!slot_q[0])        div_state_d = DIV_IDLE;
            default:     div_state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        bus.add_start    = 1'b0;
        bus.mult_start   = 1'b0;
        bus.i2f_start    = 1'b0;
        bus.f2i_start    = 1'b0;
        bus.fcmp_start   = 1'b0;
        bus.div_start    = 1'b0;
        bus.div_wb_grant = 1'b0;
        if (fire) begin
            case (bus.issue_op)
                OP_ADD:  bus.add_start  = 1'b1;
                OP_MUL:  bus.mult_start = 1'b1;
                OP_I2F:  bus.i2f_start  = 1'b1;
                OP_F2I:  bus.f2i_start  = 1'b1;
                OP_FCMP: bus.fcmp_start = 1'b1;
                OP_DIV:  bus.div_start  = 1'b1;
                default: ;
            endcase
        end
        if (div_state_q == DIV_WAIT_WB) begin
            bus.div_wb_grant = ~slot_q[0];
        end
    end
endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Randomized scoreboard bench for fpu_issue_scheduler; the reference model tracks
// normalizer bookings by absolute cycle and plays the FPU units and divider.
module tb_fpu_issue_scheduler;
    localparam int ADD_LAT  = 3;
    localparam int MUL_LAT  = 3;
    localparam int I2F_LAT  = 2;
    localparam int F2I_LAT  = 2;
    localparam int FCMP_LAT = 1;

    typedef struct {
        logic ready;
        logic grant;
        logic busy;
    } exp_t;

    logic clock;
    logic resetn;
    fpu_issue_scheduler_if bus();

    fpu_issue_scheduler dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t     exp_q[$];
    int       launch_q[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    bit       pend[32];
    bit       occ[int];
    int       wb_sched[int];
    int       div_phase;
    int       div_done_cyc;
    int       div_dest;

    function automatic int op_lat(input int op);
        case (op)
            0: return ADD_LAT;
            1: return MUL_LAT;
            2: return I2F_LAT;
            3: return F2I_LAT;
            4: return FCMP_LAT;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [5:0] actual,
                               input logic [5:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, actual, expected, cyc);
        end
    endtask

    function automatic void clear_model();
        foreach (pend[i]) pend[i] = 1'b0;
        occ.delete();
        wb_sched.delete();
        div_phase = 0;
    endfunction

    task automatic applyReset(input int ncycles);
        @(posedge clock);
        #1;
        resetn           = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_op     = 3'd0;
        bus.issue_dest   = 5'd0;
        bus.issue_src_a  = 5'd0;
        bus.issue_src_b  = 5'd0;
        bus.div_done     = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_dest      = 5'd0;
        clear_model();
        for (int i = 0; i < ncycles; i++) begin
            if (i != 0) begin
                @(posedge clock);
                #1;
            end
            exp_q.push_back('{ready: 1'b1, grant: 1'b0, busy: 1'b0});
            cyc++;
        end
        @(posedge clock);
        #1;
        resetn = 1'b1;
        cyc++;
        exp_q.push_back('{ready: 1'b1, grant: 1'b0, busy: 1'b0});
    endtask

    // One clock of stimulus; the model predicts this cycle's outputs then advances.
    task automatic applyStimulus(input bit v, input int op, input int d, input int a, input int b);
        bit   legal, uses_b, haz, res_ok, fire, dd, any_pend;
        exp_t e;
        @(posedge clock);
        #1;
        bus.wb_valid = wb_sched.exists(cyc);
        bus.wb_dest  = wb_sched.exists(cyc) ? 5'(wb_sched[cyc]) : 5'd0;
        dd = (div_phase == 1) ? (cyc == div_done_cyc) : ($urandom_range(0, 15) == 0);
        bus.div_done    = dd;
        bus.issue_valid = v;
        bus.issue_op    = 3'(op);
        bus.issue_dest  = 5'(d);
        bus.issue_src_a = 5'(a);
        bus.issue_src_b = 5'(b);

        legal  = (op < 6);
        uses_b = !(op == 2 || op == 3);
        haz    = pend[d] || pend[a] || (uses_b && pend[b]);
        if (op == 5)    res_ok = (div_phase == 0);
        else if (legal) res_ok = !occ.exists(cyc + op_lat(op));
        else            res_ok = 1'b0;
        any_pend = 1'b0;
        foreach (pend[i]) any_pend |= pend[i];
        e.ready = legal && !haz && res_ok;
        e.grant = (div_phase == 2) && !occ.exists(cyc);
        e.busy  = any_pend || (div_phase != 0);
        exp_q.push_back(e);

        fire = v && e.ready;
        if (fire) begin
            launch_q.push_back(op);
            if (op != 5) begin
                occ[cyc + op_lat(op)]          = 1'b1;
                wb_sched[cyc + op_lat(op) + 1] = d;
            end
        end
        if (bus.wb_valid) pend[bus.wb_dest] = 1'b0;
        if (fire) pend[d] = 1'b1;
        if (div_phase == 0 && fire && op == 5) begin
            div_phase    = 1;
            div_done_cyc = cyc + 1 + $urandom_range(0, 5);
            div_dest     = d;
        end else if (div_phase == 1 && dd) begin
            div_phase = 2;
        end else if (div_phase == 2 && e.grant) begin
            div_phase         = 0;
            wb_sched[cyc + 1] = div_dest;
        end
        cyc++;
    endtask

    // Monitor: compares per-cycle status and pops a launch whenever a start strobe appears.
    always @(negedge clock) begin
        exp_t       e;
        logic [5:0] starts;
        int         op;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("issue_ready", {5'd0, bus.issue_ready}, {5'd0, e.ready});
            checkOutput("div_wb_grant", {5'd0, bus.div_wb_grant}, {5'd0, e.grant});
            checkOutput("fpu_busy", {5'd0, bus.fpu_busy}, {5'd0, e.busy});
        end
        starts = {bus.div_start, bus.fcmp_start, bus.f2i_start,
                  bus.i2f_start, bus.mult_start, bus.add_start};
        if (starts != 6'd0) begin
            if (launch_q.size() == 0) begin
                checkOutput("unexpected_start", starts, 6'd0);
            end else begin
                op = launch_q.pop_front();
                checkOutput("start_strobes", starts, 6'd1 << op);
            end
        end else if (launch_q.size() > 0) begin
            op = launch_q.pop_front();
            checkOutput("missing_start", starts, 6'd1 << op);
        end
    end

    initial begin
        resetn = 1'b0;
        applyReset(2);

        // Single ADD r1 <- r2,r3 and its writeback.
        applyStimulus(1, 0, 1, 2, 3);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);

        // ADD then I2F/FCMP contention for the normalizer slot.
        applyStimulus(1, 0, 5, 30, 31);
        applyStimulus(1, 2, 6, 30, 31);
        applyStimulus(1, 4, 7, 30, 31);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);

        // RAW: MUL reading r4 while ADD r4 is outstanding.
        applyStimulus(1, 0, 4, 30, 31);
        for (int i = 0; i < 7; i++) applyStimulus(1, 1, 9, 4, 30);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);

        // Back-to-back ADD/MUL, distinct destinations.
        for (int i = 0; i < 12; i++) applyStimulus(1, i % 2, 10 + i, 30, 31);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);

        // DIV, then a second DIV offered alongside ADDs that keep slot 0 busy.
        applyStimulus(1, 5, 20, 30, 31);
        for (int i = 0; i < 14; i++) begin
            if (i % 2 == 0) applyStimulus(1, 5, 21, 30, 31);
            else            applyStimulus(1, 0, 22 + (i % 6), 30, 31);
        end
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0);

        // Randomized traffic on a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        end
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0);

        // Reset with a DIV busy and an ADD in flight.
        applyStimulus(1, 5, 20, 30, 31);
        applyStimulus(1, 0, 21, 30, 31);
        applyReset(2);
        applyStimulus(1, 0, 21, 30, 31);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0);

        @(negedge clock);
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
